// File: rtl/vx_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module   : vx_barrier_unit
// Brief    : Warp barrier tracker. Counts arrivals per barrier slot and emits
//            a one-cycle-latency release mask when the last warp arrives.
// Revision : 1.0 - initial release
// ============================================================================
module vx_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            barrier_valid,
    input  logic [$clog2(NUM_BARRIERS)-1:0] barrier_id,
    input  logic [$clog2(NUM_WARPS)-1:0]    barrier_size_m1,
    input  logic [$clog2(NUM_WARPS)-1:0]    barrier_wid,
    output logic                            barrier_ready,
    output logic                            release_valid,
    output logic [NUM_WARPS-1:0]            release_wmask,
    input  logic                            release_ready,
    output logic [NUM_WARPS-1:0]            stalled_wmask
);

    localparam int NW = $clog2(NUM_WARPS);

    logic [NW-1:0]        cnt_q [NUM_BARRIERS];
    logic [NW-1:0]        cnt_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wm_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wm_d  [NUM_BARRIERS];
    logic                 rel_valid_q, rel_valid_d;
    logic [NUM_WARPS-1:0] rel_wmask_q, rel_wmask_d;

    logic [NUM_WARPS-1:0] w_wid_oh;
    logic                 w_arrive;
    logic                 w_final;

    // Stall mask is built from registered slot state only, so it never
    // depends combinationally on the arriving request.
    always_comb begin
        stalled_wmask = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            stalled_wmask = stalled_wmask | wm_q[b];
        end
    end

    always_comb begin
        w_wid_oh              = '0;
        w_wid_oh[barrier_wid] = 1'b1;
    end

    assign barrier_ready = !reset && (!rel_valid_q || release_ready);
    assign w_arrive      = barrier_valid && barrier_ready && !stalled_wmask[barrier_wid];
    assign w_final       = (cnt_q[barrier_id] == barrier_size_m1);

    always_comb begin
        cnt_d       = cnt_q;
        wm_d        = wm_q;
        rel_valid_d = rel_valid_q;
        rel_wmask_d = rel_wmask_q;

        if (release_ready) begin
            rel_valid_d = 1'b0;
        end

        if (w_arrive) begin
            if (w_final) begin
                // Final arrival overrides a same-cycle release handshake,
                // giving back-to-back releases.
                cnt_d[barrier_id] = '0;
                wm_d[barrier_id]  = '0;
                rel_valid_d       = 1'b1;
                rel_wmask_d       = wm_q[barrier_id] | w_wid_oh;
            end else begin
                cnt_d[barrier_id] = cnt_q[barrier_id] + NW'(1);
                wm_d[barrier_id]  = wm_q[barrier_id] | w_wid_oh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                cnt_q[b] <= '0;
                wm_q[b]  <= '0;
            end
            rel_valid_q <= 1'b0;
            rel_wmask_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wm_q        <= wm_d;
            rel_valid_q <= rel_valid_d;
            rel_wmask_q <= rel_wmask_d;
        end
    end

    assign release_valid = rel_valid_q;
    assign release_wmask = rel_wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_barrier_unit
// Brief    : Directed + random bench for vx_barrier_unit against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_barrier_unit;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NB           = 2;
    localparam int NW           = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 barrier_valid;
    logic [NB-1:0]        barrier_id;
    logic [NW-1:0]        barrier_size_m1;
    logic [NW-1:0]        barrier_wid;
    logic                 barrier_ready;
    logic                 release_valid;
    logic [NUM_WARPS-1:0] release_wmask;
    logic                 release_ready;
    logic [NUM_WARPS-1:0] stalled_wmask;

    vx_barrier_unit #(
        .NUM_WARPS    (NUM_WARPS),
        .NUM_BARRIERS (NUM_BARRIERS)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .barrier_valid   (barrier_valid),
        .barrier_id      (barrier_id),
        .barrier_size_m1 (barrier_size_m1),
        .barrier_wid     (barrier_wid),
        .barrier_ready   (barrier_ready),
        .release_valid   (release_valid),
        .release_wmask   (release_wmask),
        .release_ready   (release_ready),
        .stalled_wmask   (stalled_wmask)
    );

    always #5 clk = ~clk;

    // Model: each slot is the list of warps waiting on it.
    int q [NUM_BARRIERS][$];
    int slot_sz [NUM_BARRIERS];
    bit m_rv;
    int m_rm;
    int n_vec = 0;
    int n_err = 0;

    function automatic int m_stalled();
        int s = 0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            foreach (q[b][k]) s = s | (1 << q[b][k]);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input int id, input int sz, input int wid,
                         input bit rr, input bit rst);
        bit m_ready, accept, dup;
        int m;
        reset           = rst;
        barrier_valid   = v;
        barrier_id      = NB'(id);
        barrier_size_m1 = NW'(sz);
        barrier_wid     = NW'(wid);
        release_ready   = rr;
        #1;
        m_ready = !rst && (!m_rv || rr);
        check("barrier_ready", {31'd0, barrier_ready}, {31'd0, m_ready});
        if (rst) begin
            for (int b = 0; b < NUM_BARRIERS; b++) q[b].delete();
            m_rv = 1'b0;
            m_rm = 0;
        end else begin
            accept = v && m_ready;
            dup    = ((m_stalled() >> wid) & 1) != 0;
            if (accept && !dup && q[id].size() == sz) begin
                m = 1 << wid;
                foreach (q[id][k]) m = m | (1 << q[id][k]);
                q[id].delete();
                m_rv = 1'b1;
                m_rm = m;
            end else begin
                if (accept && !dup) q[id].push_back(wid);
                if (m_rv && rr) m_rv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("stalled_wmask", 32'(stalled_wmask), 32'(m_stalled()));
        check("release_valid", {31'd0, release_valid}, {31'd0, m_rv});
        if (m_rv) check("release_wmask", 32'(release_wmask), 32'(m_rm));
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; barrier_valid = 1'b0; barrier_id = '0;
        barrier_size_m1 = '0; barrier_wid = '0; release_ready = 1'b1;
        m_rv = 1'b0; m_rm = 0;
        @(posedge clk); #1;
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        check("rst_wmask", 32'(release_wmask), 32'h0);
        check("rst_stall", 32'(stalled_wmask), 32'h0);

        // Four-warp barrier on slot 1
        cycle(1'b1, 1, 3, 0, 1'b1, 1'b0);
        check("b4_s0", 32'(stalled_wmask), 32'b0001);
        cycle(1'b1, 1, 3, 1, 1'b1, 1'b0);
        cycle(1'b1, 1, 3, 2, 1'b1, 1'b0);
        check("b4_s2", 32'(stalled_wmask), 32'b0111);
        cycle(1'b1, 1, 3, 3, 1'b1, 1'b0);
        check("b4_rel", 32'(release_wmask), 32'b1111);
        check("b4_stall", 32'(stalled_wmask), 32'b0000);

        // Single-warp barrier releases immediately (back-to-back with above)
        cycle(1'b1, 3, 0, 2, 1'b1, 1'b0);
        check("b1_rel", 32'(release_wmask), 32'b0100);
        check("b1_stall", 32'(stalled_wmask), 32'b0000);
        idle();

        // Independent slots
        cycle(1'b1, 0, 1, 0, 1'b1, 1'b0);
        cycle(1'b1, 2, 1, 1, 1'b1, 1'b0);
        cycle(1'b1, 0, 1, 3, 1'b1, 1'b0);
        check("ind_rel", 32'(release_wmask), 32'b1001);
        check("ind_stall", 32'(stalled_wmask), 32'b0010);
        cycle(1'b1, 2, 1, 2, 1'b1, 1'b0);
        check("ind_rel2", 32'(release_wmask), 32'b0110);
        idle();

        // Back-pressured release blocks new arrivals
        cycle(1'b1, 0, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2, 1, 3, 1'b0, 1'b0);
            check("bp_hold", 32'(release_wmask), 32'b0010);
        end
        cycle(1'b1, 2, 1, 3, 1'b1, 1'b0);
        check("bp_accept", 32'(stalled_wmask), 32'b1000);
        cycle(1'b1, 2, 1, 0, 1'b1, 1'b0);
        check("bp_rel", 32'(release_wmask), 32'b1001);
        idle();

        // Duplicate arrival, then reset mid-barrier
        cycle(1'b1, 0, 1, 0, 1'b1, 1'b0);
        cycle(1'b1, 0, 1, 0, 1'b1, 1'b0);
        check("dup_norel", {31'd0, release_valid}, 32'd0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        check("rst_mid", 32'(stalled_wmask), 32'h0);
        cycle(1'b1, 0, 1, 0, 1'b1, 1'b0);
        cycle(1'b1, 0, 1, 1, 1'b1, 1'b0);
        check("post_rst_rel", 32'(release_wmask), 32'b0011);
        idle();

        // Random traffic; slot size fixed while the slot has waiters
        for (int n = 0; n < 400; n++) begin
            int id;
            id = int'($urandom_range(0, NUM_BARRIERS - 1));
            if (q[id].size() == 0) slot_sz[id] = int'($urandom_range(0, NUM_WARPS - 1));
            cycle($urandom_range(0, 9) < 7, id, slot_sz[id],
                  int'($urandom_range(0, NUM_WARPS - 1)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_barrier_unit.md
VX_BARRIER_UNIT -- requirements
Module: VX_barrier_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps tracked (power of 2, >=2).
REQ-002 SHALL have parameter NUM_BARRIERS, default 4, number of barrier slots (power of 2, >=2); NB = clog2(NUM_BARRIERS), NW = clog2(NUM_WARPS).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port barrier_valid  input  1  barrier arrival request from the GPU unit.
REQ-006 SHALL have port barrier_id  input  NB  barrier slot index.
REQ-007 SHALL have port barrier_size_m1  input  NW  participating warp count minus one.
REQ-008 SHALL have port barrier_wid  input  NW  arriving warp id.
REQ-009 SHALL have port barrier_ready  output  1  arrival accepted when valid&&ready.
REQ-010 SHALL have port release_valid  output  1  release mask available to the warp scheduler.
REQ-011 SHALL have port release_wmask  output  NUM_WARPS  warps to unblock.
REQ-012 SHALL have port release_ready  input  1  scheduler accepts release when valid&&ready.
REQ-013 SHALL have port stalled_wmask  output  NUM_WARPS  warps currently blocked at any barrier.

Function
REQ-014 SHALL hold, per slot b, a registered arrival count cnt[b] (NW bits) and warp mask wm[b] (NUM_WARPS bits).
REQ-015 SHALL drive barrier_ready = !reset && (!release_valid || release_ready), combinationally.
REQ-016 SHALL treat an accepted arrival as "duplicate" when bit barrier_wid is set in stalled_wmask; duplicates SHALL change no state and produce no release.
REQ-017 On non-duplicate accepted arrival with cnt[id] != size_m1: cnt[id] += 1, wm[id] |= 1<<wid, next cycle.
REQ-018 On non-duplicate accepted arrival with cnt[id] == size_m1 (final arrival): cnt[id] <= 0, wm[id] <= 0, release_wmask <= wm[id] | (1<<wid), release_valid <= 1, all on the same edge.
REQ-019 Release latency SHALL be exactly 1 cycle: release_valid high in the cycle after the final arrival handshake.
REQ-020 size_m1 == 0 SHALL release only the arriving warp after 1 cycle; the warp never appears in stalled_wmask.
REQ-021 The final arriving warp SHALL NOT be set in stalled_wmask at any time.
REQ-022 size_m1 used for comparison SHALL be that of the current arrival; no per-slot size storage.
REQ-023 release_valid/release_wmask SHALL hold stable while release_valid && !release_ready.
REQ-024 On release handshake with no new final arrival same cycle, release_valid SHALL clear next cycle.
REQ-025 Release handshake and new final arrival in same cycle SHALL load the new mask, release_valid staying high (back-to-back releases, one per cycle).
REQ-026 stalled_wmask SHALL equal OR over b of wm[b], registered state only (no combinational path from inputs).
REQ-027 Slots SHALL be independent; arrivals to different slots never affect each other's cnt/wm.
REQ-028 cnt SHALL never exceed size_m1 of the arrivals; no wrap-around occurs since final arrival clears.

Reset
REQ-029 While reset is high: all cnt, wm, release_wmask SHALL become 0, release_valid 0, barrier_ready 0; arrivals are ignored.
REQ-030 Reset mid-operation SHALL discard partial barriers and any pending release; stalled_wmask = 0 the cycle after reset asserts.

Verification
REQ-031 4 warps, id=1, size_m1=3, wids 0,1,2 on consecutive cycles -> stalled_wmask 0001,0011,0111; wid 3 -> next cycle release_valid=1, release_wmask=1111, stalled_wmask=0000.
REQ-032 size_m1=0, wid=2 -> next cycle release_wmask=0100, stalled_wmask stays 0000.
REQ-033 Slot 0 (size_m1=1) wid 0, slot 2 (size_m1=1) wid 1, then wid 3 to slot 0 -> release 1001, stalled_wmask=0010, cnt[2]=1.
REQ-034 Pending release with release_ready=0 for 3 cycles -> barrier_ready=0, release_wmask stable; new arrival presented then is not accepted until release_ready=1.
REQ-035 wid 0 arrives twice at slot 0 (size_m1=1) -> second ignored, no release; reset asserted afterwards -> stalled_wmask=0000, release_valid=0, subsequent wid 0,1 arrivals release 0011.
